// File: rtl/multdiv_unit_pkg.sv
// Shared encodings, iteration counts and small helpers for the multiply/divide unit.
package multdiv_defs;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned MULT_ITERS = 16;
    localparam int unsigned DIV_ITERS  = 32;
    localparam int unsigned CNT_W      = $clog2(DIV_ITERS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Magnitude of a two's complement word; INT_MIN maps to 2^(W-1) read as unsigned.
    function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] x);
        return x[DATA_W-1] ? -x : x;
    endfunction

endpackage

// File: rtl/multdiv_unit_booth_r4_step.sv
// One radix-4 modified Booth iteration on the {P, B, q-1} accumulator.
module booth_r4_step #(
    parameter int unsigned W = 32
) (
    input  logic [2*W+1:0] acc_i,
    input  logic [W-1:0]   mcand_i,
    output logic [2*W+1:0] acc_o
);

    logic [W+1:0] a1;
    logic [W+1:0] a2;
    logic [W+1:0] addend;
    logic [W+1:0] hi;
    logic [W+1:0] sum;

    assign a1 = {{2{mcand_i[W-1]}}, mcand_i};
    assign a2 = {mcand_i[W-1], mcand_i, 1'b0};
    // One guard bit above P so that -2*INT_MIN does not wrap before the shift.
    assign hi = {acc_i[2*W+1], acc_i[2*W+1:W+1]};

    always_comb begin
        addend = '0;
        unique case (acc_i[2:0])
            3'b001, 3'b010: addend = a1;
            3'b011:         addend = a2;
            3'b100:         addend = -a2;
            3'b101, 3'b110: addend = -a1;
            default:        addend = '0;
        endcase
    end

    assign sum   = hi + addend;
    assign acc_o = {sum[W+1], sum, acc_i[W:2]};

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (radix-4 Booth) / divide (non-restoring) unit with start/ready handshake.
module multdiv_unit
    import multdiv_defs::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_operandA,
    input  logic [DATA_WIDTH-1:0] data_operandB,
    input  logic                  ctrl_MULT,
    input  logic                  ctrl_DIV,
    output logic [DATA_WIDTH-1:0] data_result,
    output logic                  data_exception,
    output logic                  data_resultRDY
);

    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned AW = 2 * W + 2;
    localparam logic [W-1:0] INT_MIN = {1'b1, {(W-1){1'b0}}};

    state_e         state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]  acc_q, acc_d;
    logic [W-1:0]   opnd_q, opnd_d;
    logic           neg_q, neg_d;
    logic           ovf_q, ovf_d;
    logic [W-1:0]   result_q, result_d;
    logic           exc_q, exc_d;
    logic           rdy_q, rdy_d;

    logic [AW-1:0]  booth_next;
    logic [AW-1:0]  div_next;
    logic [W+1:0]   rem, rem_sh, rem_nx;
    logic [W-1:0]   quo, quo_nx;
    logic [W:0]     prod_hi;

    booth_r4_step #(.W(W)) u_booth (
        .acc_i   (acc_q),
        .mcand_i (opnd_q),
        .acc_o   (booth_next)
    );

    // Divide shares the accumulator: {remainder[W+1:0], quotient/dividend[W-1:0]}.
    assign rem      = acc_q[AW-1:W];
    assign quo      = acc_q[W-1:0];
    assign rem_sh   = {rem[W:0], quo[W-1]};
    assign rem_nx   = rem[W+1] ? (rem_sh + {2'b00, opnd_q}) : (rem_sh - {2'b00, opnd_q});
    assign quo_nx   = {quo[W-2:0], ~rem_nx[W+1]};
    assign div_next = {rem_nx, quo_nx};

    // Signed product bits [2W-1:W-1] must all match for the low word to be exact.
    assign prod_hi = booth_next[2*W:W];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;
        result_d = result_q;
        exc_d    = exc_q;

        if (ctrl_MULT) begin
            state_d = MULT;
            cnt_d   = '0;
            acc_d   = {{(W+1){1'b0}}, data_operandB, 1'b0};
            opnd_d  = data_operandA;
            exc_d   = 1'b0;
        end else if (ctrl_DIV) begin
            cnt_d = '0;
            if (data_operandB == '0) begin
                state_d  = DONE;
                result_d = '0;
                exc_d    = 1'b1;
            end else begin
                state_d = DIV;
                acc_d   = {{(W+2){1'b0}}, abs_val(data_operandA)};
                opnd_d  = abs_val(data_operandB);
                neg_d   = data_operandA[W-1] ^ data_operandB[W-1];
                ovf_d   = (data_operandA == INT_MIN) && (data_operandB == '1);
                exc_d   = 1'b0;
            end
        end else begin
            unique case (state_q)
                IDLE: state_d = IDLE;
                MULT: begin
                    acc_d = booth_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(MULT_ITERS - 1)) begin
                        state_d  = DONE;
                        cnt_d    = '0;
                        result_d = booth_next[W:1];
                        exc_d    = ~((&prod_hi) | ~(|prod_hi));
                    end
                end
                DIV: begin
                    acc_d = div_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DIV_ITERS - 1)) begin
                        state_d  = DONE;
                        cnt_d    = '0;
                        result_d = neg_q ? -quo_nx : quo_nx;
                        exc_d    = ovf_q;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        rdy_d = (state_d == DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;

endmodule
